// File: rtl/ws2812_window_decoder.sv
// WS2812 line decoder: synchronise, time high/low intervals with one counter, classify against windows.
// Define WS2812_DECODER_LOWCHECK_EN to defer bits to the end of their period and check the total period.
module ws2812_window_decoder #(
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned T0H_MIN       = 10,
  parameter int unsigned T0H_MAX       = 30,
  parameter int unsigned T1H_MIN       = 31,
  parameter int unsigned T1H_MAX       = 50,
  parameter int unsigned TBIT_MIN      = 50,
  parameter int unsigned TBIT_MAX      = 80,
  parameter int unsigned TRESET_CYCLES = 2500
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_din,
  output logic       o_bit,
  output logic       o_bit_valid,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_treset,
  output logic       o_idle
);

  localparam int unsigned CNT_SAT = (32'd1 << CNT_W) - 32'd1;

  localparam logic [CNT_W-1:0] T0H_MIN_C  = CNT_W'(T0H_MIN);
  localparam logic [CNT_W-1:0] T0H_MAX_C  = CNT_W'(T0H_MAX);
  localparam logic [CNT_W-1:0] T1H_MIN_C  = CNT_W'(T1H_MIN);
  localparam logic [CNT_W-1:0] T1H_MAX_C  = CNT_W'(T1H_MAX);
  localparam logic [CNT_W-1:0] TRESET_C   = CNT_W'(TRESET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] ERR_HIGH_WIN = 2'b01;
  localparam logic [1:0] ERR_STUCK    = 2'b10;
`ifdef WS2812_DECODER_LOWCHECK_EN
  localparam int unsigned       SUM_W      = CNT_W + 1;
  localparam logic [SUM_W-1:0]  TBIT_MIN_C = SUM_W'(TBIT_MIN);
  localparam logic [SUM_W-1:0]  TBIT_MAX_C = SUM_W'(TBIT_MAX);
  localparam logic [1:0]        ERR_PERIOD = 2'b11;
`endif

  // Elaboration-time sanity of the timing windows
  if (SYNC_STAGES < 2) begin : g_sync_check
    $error("ws2812_window_decoder: SYNC_STAGES must be >= 2");
  end
  if (!(T0H_MIN <= T0H_MAX && T0H_MAX < T1H_MIN && T1H_MIN <= T1H_MAX &&
        T1H_MAX < TBIT_MAX && TBIT_MIN <= TBIT_MAX && TBIT_MAX < TRESET_CYCLES &&
        TRESET_CYCLES < CNT_SAT)) begin : g_order_check
    $error("ws2812_window_decoder: illegal timing parameter ordering");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2,
    ST_RESYNC = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q;
  logic                   rise_q;
  logic                   fall_q;
  logic [CNT_W-1:0]       cnt;
  state_t                 state;

  logic high_is_zero;
  logic high_is_one;
  logic cnt_at_treset;

`ifdef WS2812_DECODER_LOWCHECK_EN
  logic [CNT_W-1:0] h_len;
  logic             pend_valid;
  logic             pend_bit;
  logic [SUM_W-1:0] bit_period;
  logic             period_ok;
`endif

  // Input synchroniser
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_din};
    end
  end

  // Registered edge detector; s_q is the line level aligned with the edge pulses
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s_q    <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~s_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & s_q;
    end
  end

  // Shared interval counter: holds the interval length in the cycle of the terminating edge
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (rise_q || fall_q) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_W'(CNT_SAT)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign high_is_zero  = (cnt >= T0H_MIN_C) && (cnt <= T0H_MAX_C);
  assign high_is_one   = (cnt >= T1H_MIN_C) && (cnt <= T1H_MAX_C);
  assign cnt_at_treset = (cnt == TRESET_C);

`ifdef WS2812_DECODER_LOWCHECK_EN
  // Period sum is one bit wider than the counter so it cannot wrap
  assign bit_period = {1'b0, h_len} + {1'b0, cnt};
  assign period_ok  = (bit_period >= TBIT_MIN_C) && (bit_period <= TBIT_MAX_C);
`endif

  // Decoder FSM with registered pulse outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      o_bit       <= 1'b0;
      o_bit_valid <= 1'b0;
      o_err       <= 1'b0;
      o_err_code  <= 2'b00;
      o_treset    <= 1'b0;
      o_idle      <= 1'b1;
`ifdef WS2812_DECODER_LOWCHECK_EN
      h_len       <= '0;
      pend_valid  <= 1'b0;
      pend_bit    <= 1'b0;
`endif
    end else begin
      o_bit_valid <= 1'b0;
      o_err       <= 1'b0;
      o_treset    <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (rise_q) begin
            state  <= ST_HIGH;
            o_idle <= 1'b0;
          end
        end

        ST_HIGH: begin
          if (fall_q) begin
            state <= ST_LOW;
            if (high_is_one || high_is_zero) begin
`ifdef WS2812_DECODER_LOWCHECK_EN
              pend_valid <= 1'b1;
              pend_bit   <= high_is_one;
              h_len      <= cnt;
`else
              o_bit_valid <= 1'b1;
              o_bit       <= high_is_one;
`endif
            end else begin
              o_err      <= 1'b1;
              o_err_code <= ERR_HIGH_WIN;
`ifdef WS2812_DECODER_LOWCHECK_EN
              pend_valid <= 1'b0;
`endif
            end
          end else if (cnt > T1H_MAX_C) begin
            state      <= ST_RESYNC;
            o_err      <= 1'b1;
            o_err_code <= ERR_STUCK;
          end
        end

        ST_LOW: begin
          if (rise_q) begin
            state <= ST_HIGH;
`ifdef WS2812_DECODER_LOWCHECK_EN
            if (pend_valid) begin
              if (period_ok) begin
                o_bit_valid <= 1'b1;
                o_bit       <= pend_bit;
              end else begin
                o_err      <= 1'b1;
                o_err_code <= ERR_PERIOD;
              end
            end
            pend_valid <= 1'b0;
`endif
          end else if (cnt_at_treset) begin
            state    <= ST_IDLE;
            o_idle   <= 1'b1;
            o_treset <= 1'b1;
`ifdef WS2812_DECODER_LOWCHECK_EN
            // Last bit of the frame has no closing rise; release it with the reset pulse
            if (pend_valid) begin
              o_bit_valid <= 1'b1;
              o_bit       <= pend_bit;
            end
            pend_valid <= 1'b0;
`endif
          end
        end

        ST_RESYNC: begin
          if (!s_q && cnt_at_treset) begin
            state    <= ST_IDLE;
            o_idle   <= 1'b1;
            o_treset <= 1'b1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          o_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_window_decoder.sv
// Bench for ws2812_window_decoder: table-driven bit stream plus hand sequences, scoreboarded pulses.
`timescale 1ns/1ps
module tb_ws2812_window_decoder;

  localparam int LAT  = 3;     // transition edge to registered output, with SYNC_STAGES = 2
  localparam int TRST = 2500;

  typedef enum int {K_NONE, K_BIT, K_ERR} kind_e;

  typedef struct {
    int    h;
    int    l;
    kind_e dk;   // event at the falling edge, default build
    int    dv;
    kind_e lk;   // event at the closing rise, low-check build
    int    lv;
  } vec_t;

  typedef struct {
    int         cyc;
    logic       bv;
    logic       b;
    logic       er;
    logic [1:0] code;
    logic       tr;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       o_bit, o_bit_valid, o_err, o_treset, o_idle;
  logic [1:0] o_err_code;

  int  cyc = 0;
  int  checks = 0;
  int  passed = 0;
  ev_t exp_q[$];

  ws2812_window_decoder dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_din       (din),
    .o_bit       (o_bit),
    .o_bit_valid (o_bit_valid),
    .o_err       (o_err),
    .o_err_code  (o_err_code),
    .o_treset    (o_treset),
    .o_idle      (o_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Queue an expected pulse; events in the same cycle merge into one record
  task automatic push(input int c, input kind_e k, input int v, input logic tr);
    ev_t e;
    e.cyc = c; e.bv = 1'b0; e.b = 1'b0; e.er = 1'b0; e.code = 2'b00; e.tr = 1'b0;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == c) e = exp_q.pop_back();
    if (k == K_BIT) begin e.bv = 1'b1; e.b = v[0]; end
    else if (k == K_ERR) begin e.er = 1'b1; e.code = v[1:0]; end
    if (tr) e.tr = 1'b1;
    exp_q.push_back(e);
  endtask

  // Drive a line level for n cycles; t is the clock edge that first samples it
  task automatic seg(input logic v, input int n, output int t);
    din = v;
    t = cyc + 1;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor, sampling 1 ns after each rising edge
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (o_bit_valid || o_err || o_treset) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pulse cyc=%0d actual bv=%b b=%b err=%b code=%b tr=%b required none",
                   cyc, o_bit_valid, o_bit, o_err, o_err_code, o_treset);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc == cyc && o_bit_valid == e.bv && o_err == e.er && o_treset == e.tr &&
              (!e.bv || o_bit == e.b) && (!e.er || o_err_code == e.code))
            passed++;
          else
            $display("FAIL pulse cyc=%0d actual bv=%b b=%b err=%b code=%b tr=%b required cyc=%0d bv=%b b=%b err=%b code=%b tr=%b",
                     cyc, o_bit_valid, o_bit, o_err, o_err_code, o_treset,
                     e.cyc, e.bv, e.b, e.er, e.code, e.tr);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        e = exp_q.pop_front();
        $display("FAIL missed_pulse actual none at cyc=%0d required bv=%b b=%b err=%b code=%b tr=%b",
                 e.cyc, e.bv, e.b, e.er, e.code, e.tr);
      end
    end
  end

  initial begin
    vec_t vecs[14];
    int   t, tr, tf, tr2, tf2;

    vecs[0]  = '{40, 25, K_BIT, 1, K_BIT, 1};
    vecs[1]  = '{20, 45, K_BIT, 0, K_BIT, 0};
    vecs[2]  = '{ 5, 60, K_ERR, 1, K_NONE, 0};
    vecs[3]  = '{30, 40, K_BIT, 0, K_BIT, 0};
    vecs[4]  = '{31, 40, K_BIT, 1, K_BIT, 1};
    vecs[5]  = '{10, 50, K_BIT, 0, K_BIT, 0};
    vecs[6]  = '{50, 30, K_BIT, 1, K_BIT, 1};
    vecs[7]  = '{51, 20, K_ERR, 1, K_NONE, 0};
    vecs[8]  = '{ 9, 50, K_ERR, 1, K_NONE, 0};
    vecs[9]  = '{40,  5, K_BIT, 1, K_ERR, 3};
    vecs[10] = '{40, 40, K_BIT, 1, K_BIT, 1};
    vecs[11] = '{40, 41, K_BIT, 1, K_ERR, 3};
    vecs[12] = '{20, 29, K_BIT, 0, K_ERR, 3};
    vecs[13] = '{20, 30, K_BIT, 0, K_BIT, 0};

    // Reset, then a quiet line for 100 cycles
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("reset_bit",        32'(o_bit),       32'd0);
    chk("reset_bit_valid",  32'(o_bit_valid), 32'd0);
    chk("reset_err",        32'(o_err),       32'd0);
    chk("reset_err_code",   32'(o_err_code),  32'd0);
    chk("reset_treset",     32'(o_treset),    32'd0);
    chk("reset_idle",       32'(o_idle),      32'd1);

    // Continuous bit stream from the table
    foreach (vecs[i]) begin
      tr = cyc + 1;
      tf = tr + vecs[i].h;
      tr2 = tf + vecs[i].l;
`ifdef WS2812_DECODER_LOWCHECK_EN
      if (vecs[i].dk == K_ERR) push(tf + LAT, K_ERR, vecs[i].dv, 1'b0);
      if (vecs[i].lk != K_NONE) push(tr2 + LAT, vecs[i].lk, vecs[i].lv, 1'b0);
`else
      push(tf + LAT, vecs[i].dk, vecs[i].dv, 1'b0);
`endif
      seg(1'b1, vecs[i].h, t);
      seg(1'b0, vecs[i].l, t);
    end

    // Frame: 40/25, 20/long low ending in a frame reset
    tr  = cyc + 1;
    tf  = tr + 40;
    tr2 = tf + 25;
    tf2 = tr2 + 20;
`ifdef WS2812_DECODER_LOWCHECK_EN
    push(tr2 + LAT, K_BIT, 1, 1'b0);
    push(tf2 + LAT + TRST, K_BIT, 0, 1'b1);
`else
    push(tf + LAT, K_BIT, 1, 1'b0);
    push(tf2 + LAT, K_BIT, 0, 1'b0);
    push(tf2 + LAT + TRST, K_NONE, 0, 1'b1);
`endif
    seg(1'b1, 40, t);
    seg(1'b0, 25, t);
    seg(1'b1, 20, t);
    seg(1'b0, 3000, t);
    chk("frame_idle",     32'(o_idle), 32'd1);
    chk("frame_bit_hold", 32'(o_bit),  32'd0);

    // Stuck high, ignored bits while resynchronising, then a frame reset
    tr = cyc + 1;
    push(tr + LAT + 51, K_ERR, 2, 1'b0);
    seg(1'b1, 200, t);
    chk("stuck_idle", 32'(o_idle), 32'd0);
    seg(1'b0, 100, t);
    seg(1'b1, 40, t);
    push(cyc + 1 + LAT + TRST, K_NONE, 0, 1'b1);
    seg(1'b0, 3000, t);
    chk("resync_idle",     32'(o_idle),     32'd1);
    chk("stuck_code_hold", 32'(o_err_code), 32'd2);

    // Reset in the middle of a high interval
    seg(1'b1, 15, t);
    rst_n = 1'b0;
    din   = 1'b0;
    #1;
    chk("midrst_bit_valid", 32'(o_bit_valid), 32'd0);
    chk("midrst_err",       32'(o_err),       32'd0);
    chk("midrst_err_code",  32'(o_err_code),  32'd0);
    chk("midrst_treset",    32'(o_treset),    32'd0);
    chk("midrst_idle",      32'(o_idle),      32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seg(1'b0, 10, t);
    tr = cyc + 1;
    tf = tr + 20;
`ifdef WS2812_DECODER_LOWCHECK_EN
    push(tf + LAT + TRST, K_BIT, 0, 1'b1);
`else
    push(tf + LAT, K_BIT, 0, 1'b0);
    push(tf + LAT + TRST, K_NONE, 0, 1'b1);
`endif
    seg(1'b1, 20, t);
    seg(1'b0, 3000, t);
    chk("post_rst_idle", 32'(o_idle), 32'd1);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ws2812_window_decoder.md
# ws2812_window_decoder

Parametrised WS2812 serial decoder. It synchronises the raw data line, measures each high and low interval with one shared saturating counter, and classifies bits against configurable window comparators. It emits one decoded-bit pulse per valid bit, along with error and frame-reset indications. It sits between the LED data input pin and the bit shift register, and replaces the fixed-width, high-time-only decoder stage.

## Interface
Parameters:
- CNT_W, 12: interval counter width; saturates at 2^CNT_W-1.
- SYNC_STAGES, 2: input synchroniser depth (>=2).
- T0H_MIN, 10 / T0H_MAX, 30: high-time window for a 0 bit, in cycles.
- T1H_MIN, 31 / T1H_MAX, 50: high-time window for a 1 bit, in cycles.
- TBIT_MIN, 50 / TBIT_MAX, 80: total bit-period window (high+low), in cycles; used only with the low check compiled in.
- TRESET_CYCLES, 2500: low time that declares a frame reset.
- Legal parameter ordering: T0H_MIN<=T0H_MAX<T1H_MIN<=T1H_MAX<TBIT_MAX<TRESET_CYCLES<2^CNT_W-1. This is checked at elaboration with $error.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_din  in  1  raw asynchronous WS2812 data line.
- o_bit  out  1  decoded bit value; valid only while o_bit_valid is high.
- o_bit_valid  out  1  one-cycle pulse per accepted bit.
- o_err  out  1  one-cycle error pulse.
- o_err_code  out  2  error cause, valid with o_err: 01 high out of window, 10 stuck high, 11 bit period out of window.
- o_treset  out  1  one-cycle pulse when a frame reset is detected.
- o_idle  out  1  level; high in IDLE.

## Operation
- The synchroniser feeds an edge detector that produces a rise or fall pulse on the synchronised signal s.
- Counter cnt:
  - Loads 1 in the cycle after any edge.
  - Otherwise increments, saturating.
  - The interval length equals the value of cnt in the cycle the terminating edge is detected.
- FSM states: IDLE, HIGH, LOW, RESYNC. Reset enters IDLE with cnt=0.
- IDLE: rise -> HIGH.
- HIGH:
  - fall with H in [T1H_MIN,T1H_MAX] -> pending bit 1.
  - fall with H in [T0H_MIN,T0H_MAX] -> pending bit 0.
  - Either valid case -> LOW.
  - fall with H in neither window -> o_err, code 01; pending marked invalid; -> LOW.
  - cnt > T1H_MAX with no fall -> o_err, code 10; -> RESYNC.
- LOW:
  - rise -> HIGH, with the bit action defined under Configuration.
  - cnt == TRESET_CYCLES -> o_treset; -> IDLE.
- RESYNC:
  - rise reloads cnt.
  - Low for TRESET_CYCLES -> o_treset; -> IDLE.
  - No bits are emitted in this state.
- Period sum H+L is computed at CNT_W+1 bits; no wrap.
- At most one of o_bit_valid and o_err is asserted in any cycle.
- Reset mid-bit discards the pending bit with no pulse. The first rise after reset is decoded normally.

## Timing
- Reset values: o_bit=0, o_bit_valid=0, o_err=0, o_err_code=00, o_treset=0, o_idle=1; synchroniser flops=0.
- All outputs are registered.
- The edge pulse is available SYNC_STAGES+1 cycles after an i_din transition.
- Outputs assert 1 cycle after the edge or threshold cycle, i.e. SYNC_STAGES+2 cycles after the i_din transition.
- o_bit holds its value until the next o_bit_valid.
- o_err_code holds its value until the next o_err.
- o_treset pulses exactly once per reset interval; a continued low does not re-pulse it.

## Configuration
- Macro: WS2812_DECODER_LOWCHECK_EN.
- Defined:
  - A valid bit is emitted at the rise that ends its low time, only if H+L is in [TBIT_MIN,TBIT_MAX]. Otherwise o_err with code 11, and the bit is dropped.
  - At reset detection, a valid pending bit is emitted in the same cycle as o_treset. This is the frame's last bit.
  - An invalid pending bit produces no further error.
- Undefined:
  - A valid bit is emitted at the falling edge (o_bit_valid SYNC_STAGES+2 cycles after i_din falls).
  - Low time is checked only against TRESET_CYCLES.
  - Code 11 never occurs.
  - TBIT_MIN and TBIT_MAX are ignored.

## Test plan
- After reset with i_din=0 for 100 cycles -> all outputs at reset values, o_idle=1, no pulses.
- High 40 / low 25, then high 20 / low 45, then low 3000:
  - Pulses with o_bit 1 then 0.
  - One o_treset once cnt reaches 2500.
  - Under LOWCHECK, the second bit pulses in the o_treset cycle.
- High 5 / low 60 -> o_err with code 01 and no o_bit_valid. High 30 (T0H_MAX) and high 31 (T1H_MIN) -> bits 0 and 1.
- i_din high for 200 cycles:
  - o_err with code 10 when cnt reaches 51, and o_idle=0.
  - Bits are ignored until a 2500-cycle low; then o_treset fires and o_idle=1.
- LOWCHECK: high 40 / low 5 (sum 45) -> o_err with code 11 at the rise, no bit. High 40 / low 40 (sum 80) -> bit 1 accepted.
- i_reset_n asserted mid-high, then released -> outputs return to reset values immediately, no pulses; the next 20/50 bit decodes as 0.
